// File: rtl/mem_wb_load_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_load_stage_if
//  Brief    : MEM->WB load-stage bundle: MEM-stage inputs, hazard controls
//             and registered WB-stage outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_wb_load_stage_if #(
    parameter int CNT_W = 16
);
    // hazard control
    logic             stall_W;
    logic             flush_W;
    // MEM-stage side
    logic             valid_M;
    logic             reg_write_M;
    logic [4:0]       rd_M;
    logic [1:0]       result_src_M;
    logic [2:0]       load_sel_M;
    logic [31:0]      alu_result_M;
    logic [31:0]      pc_plus4_M;
    logic [31:0]      mem_RD;
    // WB-stage side
    logic             valid_W;
    logic             reg_write_W;
    logic [4:0]       rd_W;
    logic [31:0]      result_W;
    logic             load_misalign_W;
    logic [CNT_W-1:0] misalign_cnt;

    // upstream pipeline / memory / hazard unit view
    modport master (
        output stall_W, flush_W, valid_M, reg_write_M, rd_M, result_src_M,
               load_sel_M, alu_result_M, pc_plus4_M, mem_RD,
        input  valid_W, reg_write_W, rd_W, result_W, load_misalign_W, misalign_cnt
    );

    // stage view
    modport slave (
        input  stall_W, flush_W, valid_M, reg_write_M, rd_M, result_src_M,
               load_sel_M, alu_result_M, pc_plus4_M, mem_RD,
        output valid_W, reg_write_W, rd_W, result_W, load_misalign_W, misalign_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_load_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_load_stage
//  Brief    : Extracts/extends load data from the raw memory word, selects the
//             writeback result, flags and counts misaligned/illegal loads and
//             registers everything into WB with stall/flush control.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_load_stage #(
    parameter int CNT_W = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    mem_wb_load_stage_if.slave  bus
);

    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;

    localparam logic [1:0] c_SRC_LOAD = 2'b01;
    localparam logic [1:0] c_SRC_PC4  = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_load_err;
    logic [31:0] w_load_data;
    logic        w_bad;
    logic [31:0] w_result;
    logic        w_reg_write;

    logic             r_valid_W;
    logic             r_reg_write_W;
    logic [4:0]       r_rd_W;
    logic [31:0]      r_result_W;
    logic             r_load_misalign_W;
    logic [CNT_W-1:0] r_misalign_cnt;

    assign w_off  = bus.alu_result_M[1:0];
    assign w_byte = bus.mem_RD[8*w_off +: 8];
    assign w_half = w_off[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];

    // Load extraction; misaligned or unknown load types return zero data
    always_comb begin
        w_load_err  = 1'b0;
        w_load_data = 32'd0;
        case (bus.load_sel_M)
            c_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LBU: w_load_data = {24'd0, w_byte};
            c_LH: begin
                w_load_err  = w_off[0];
                w_load_data = w_off[0] ? 32'd0 : {{16{w_half[15]}}, w_half};
            end
            c_LHU: begin
                w_load_err  = w_off[0];
                w_load_data = w_off[0] ? 32'd0 : {16'd0, w_half};
            end
            c_LW: begin
                w_load_err  = (w_off != 2'b00);
                w_load_data = (w_off != 2'b00) ? 32'd0 : bus.mem_RD;
            end
            default: begin
                w_load_err  = 1'b1;
                w_load_data = 32'd0;
            end
        endcase
    end

    // A fault only counts for a live instruction that actually writes back load data
    assign w_bad = bus.valid_M && (bus.result_src_M == c_SRC_LOAD) && w_load_err;

    // Writeback source mux; both 00 and 11 select the ALU result
    always_comb begin
        w_result = bus.alu_result_M;
        if (bus.result_src_M == c_SRC_LOAD) begin
            w_result = w_load_data;
        end else if (bus.result_src_M == c_SRC_PC4) begin
            w_result = bus.pc_plus4_M;
        end
    end

    assign w_reg_write = bus.reg_write_M && bus.valid_M && !w_bad && (bus.rd_M != 5'd0);

    // WB pipeline registers: reset > flush > stall > normal
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_W         <= 1'b0;
            r_reg_write_W     <= 1'b0;
            r_rd_W            <= 5'd0;
            r_result_W        <= 32'd0;
            r_load_misalign_W <= 1'b0;
        end else if (bus.flush_W) begin
            r_valid_W         <= 1'b0;
            r_reg_write_W     <= 1'b0;
            r_rd_W            <= 5'd0;
            r_result_W        <= 32'd0;
            r_load_misalign_W <= 1'b0;
        end else if (!bus.stall_W) begin
            r_valid_W         <= bus.valid_M;
            r_reg_write_W     <= w_reg_write;
            r_rd_W            <= bus.rd_M;
            r_result_W        <= w_result;
            r_load_misalign_W <= w_bad;
        end
    end

    // Saturating fault counter; flushed or stalled instructions never retire so never count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign_cnt <= '0;
        end else if (!bus.flush_W && !bus.stall_W && w_bad && (r_misalign_cnt != c_CNT_MAX)) begin
            r_misalign_cnt <= r_misalign_cnt + 1'b1;
        end
    end

    assign bus.valid_W         = r_valid_W;
    assign bus.reg_write_W     = r_reg_write_W;
    assign bus.rd_W            = r_rd_W;
    assign bus.result_W        = r_result_W;
    assign bus.load_misalign_W = r_load_misalign_W;
    assign bus.misalign_cnt    = r_misalign_cnt;

endmodule
`default_nettype wire
